uart_rx_ctrl: RTL
=================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning frame data bits.
REQ-002 SHALL have parameter PRESC_W, default 6, meaning Prescale width.
REQ-003 SHALL have port CLK  in  1  oversampling clock.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port RX_IN  in  1  serial line, idle high.
REQ-006 SHALL have port PAR_EN  in  1  parity bit present.
REQ-007 SHALL have port Prescale  in  PRESC_W  samples per bit; legal values 8, 16, 32.
REQ-008 SHALL have port par_err  in  1  parity checker result.
REQ-009 SHALL have port sampled_bit  out  1  majority-voted bit value.
REQ-010 SHALL have port par_chk_en  out  1  one-cycle parity-check strobe.
REQ-011 SHALL have port par_deassert  out  1  one-cycle checker clear at frame start.
REQ-012 SHALL have port P_DATA  out  DATA_W  received byte, LSB first on the line.
REQ-013 SHALL have port data_valid  out  1  one-cycle good-frame pulse.
REQ-014 SHALL have port stp_err  out  1  stop-bit error flag.

Function
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL use edge counter edge_cnt 0..Prescale-1, one count per CLK, wrapping to 0 with bit_cnt+1.
REQ-017 SHALL capture RX_IN at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1, then register the 2-of-3 majority into sampled_bit at edge_cnt = Prescale/2+2.
REQ-018 IDLE: RX_IN=0 SHALL move to START with edge_cnt=0 and bit_cnt=0, and SHALL pulse par_deassert in the same cycle.
REQ-019 START: at edge_cnt = Prescale-1, SHALL move to DATA.
REQ-020 DATA: SHALL shift sampled_bit into P_DATA (LSB first) one cycle after each decision; after DATA_W bits, SHALL move to PARITY if PAR_EN=1, else to STOP.
REQ-021 PARITY: SHALL assert par_chk_en for exactly the cycle after the parity decision; at edge_cnt = Prescale-1, SHALL latch par_err into an internal flag and move to STOP.
REQ-022 STOP: the cycle after the stop decision SHALL set stp_err = ~sampled_bit, and SHALL pulse data_valid iff sampled_bit=1 and (PAR_EN=0 or latched par_err=0).
REQ-023 STOP: at edge_cnt = Prescale-1, SHALL return to IDLE; a new start bit may then be accepted in the immediately following cycle.
REQ-024 P_DATA SHALL hold its value from frame completion until the first DATA shift of the next frame.
REQ-025 stp_err SHALL hold until the next par_deassert cycle, which clears it.
REQ-026 PAR_EN and Prescale changes SHALL take effect only in IDLE; values are latched on start detection.
REQ-027 An illegal Prescale SHALL be treated as 8.

Reset
REQ-028 RST low SHALL immediately force IDLE, clear edge_cnt, bit_cnt, P_DATA, sampled_bit, par_chk_en, par_deassert, data_valid and stp_err to 0.
REQ-029 Reset mid-frame SHALL discard the partial frame with no data_valid or error pulse after release.

Configuration
REQ-030 With macro UART_RX_STRT_GLITCH_CHK_EN defined: a START decision of sampled_bit=1 SHALL return to IDLE, without data_valid or stp_err.
REQ-031 Without UART_RX_STRT_GLITCH_CHK_EN: START SHALL ignore sampled_bit and always proceed to DATA.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the legal Prescale constants 8/16/32, and the sample-point offsets.
REQ-033 One sub-module, uart_rx_sampler, SHALL contain the edge counter, the three sample captures and the majority vote; the FSM, bit counter and deserializer SHALL stay in uart_rx_ctrl.

Verification
REQ-034 Prescale=8, PAR_EN=1, frame 0xA5 with parity bit 0 and checker in even mode -> par_chk_en one pulse, data_valid one pulse, P_DATA=0xA5, stp_err=0.
REQ-035 Same frame with parity bit 1 -> par_err=1 latched, no data_valid, stp_err=0.
REQ-036 Prescale=16, PAR_EN=0, frame 0x3C with stop bit 0 -> stp_err=1, no data_valid, P_DATA=0x3C.
REQ-037 With UART_RX_STRT_GLITCH_CHK_EN, Prescale=8: RX_IN low for 2 CLK then high -> return to IDLE, no pulses, next valid frame 0x81 received correctly.
REQ-038 Two back-to-back frames 0x55 then 0xAA with no idle gap, Prescale=32 -> two data_valid pulses spaced 10*32 CLK apart (PAR_EN=0).
REQ-039 RST asserted mid-DATA of frame 0xFF -> all outputs 0, FSM in IDLE, no pulses after release.

Source files
------------

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller and its sampler.
package uart_rx_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int unsigned PRESC_8  = 8;
    localparam int unsigned PRESC_16 = 16;
    localparam int unsigned PRESC_32 = 32;

    // Offsets relative to Prescale/2: three captures, the vote, and the cycle the vote is visible
    localparam int unsigned SMP_OFS_EARLY = 1;
    localparam int unsigned SMP_OFS_LATE  = 1;
    localparam int unsigned SMP_OFS_DEC   = 2;
    localparam int unsigned SMP_OFS_RDY   = 3;

    function automatic int unsigned presc_legal(input int unsigned presc);
        if (presc == PRESC_16 || presc == PRESC_32) begin
            return presc;
        end
        return PRESC_8;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversampling edge counter with three mid-bit captures and a 2-of-3 majority vote.
module uart_rx_sampler
    import uart_rx_ctrl_pkg::*;
#(
    parameter int unsigned PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               rx_i,
    input  logic               run_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic [PRESC_W-1:0] edge_cnt_o,
    output logic               sampled_bit_o
);

    logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [2:0]         smp_q, smp_d;
    logic               sampled_bit_q, sampled_bit_d;

    logic [PRESC_W-1:0] half_c;
    logic [PRESC_W-1:0] pt_early_c;
    logic [PRESC_W-1:0] pt_late_c;
    logic [PRESC_W-1:0] pt_dec_c;

    always_comb begin
        half_c        = presc_i >> 1;
        pt_early_c    = half_c - PRESC_W'(SMP_OFS_EARLY);
        pt_late_c     = half_c + PRESC_W'(SMP_OFS_LATE);
        pt_dec_c      = half_c + PRESC_W'(SMP_OFS_DEC);

        edge_cnt_d    = edge_cnt_q;
        smp_d         = smp_q;
        sampled_bit_d = sampled_bit_q;

        if (!run_i) begin
            edge_cnt_d = '0;
        end else begin
            if (edge_cnt_q == presc_i - PRESC_W'(1)) begin
                edge_cnt_d = '0;
            end else begin
                edge_cnt_d = edge_cnt_q + PRESC_W'(1);
            end
            if (edge_cnt_q == pt_early_c) smp_d[0] = rx_i;
            if (edge_cnt_q == half_c)     smp_d[1] = rx_i;
            if (edge_cnt_q == pt_late_c)  smp_d[2] = rx_i;
            if (edge_cnt_q == pt_dec_c) begin
                sampled_bit_d = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) |
                                (smp_q[1] & smp_q[2]);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q    <= '0;
            smp_q         <= '0;
            sampled_bit_q <= 1'b0;
        end else begin
            edge_cnt_q    <= edge_cnt_d;
            smp_q         <= smp_d;
            sampled_bit_q <= sampled_bit_d;
        end
    end

    assign edge_cnt_o    = edge_cnt_q;
    assign sampled_bit_o = sampled_bit_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, bit counter and deserializer around uart_rx_sampler.
// Define UART_RX_STRT_GLITCH_CHK_EN to drop start bits that vote high.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               par_err,
    output logic               sampled_bit,
    output logic               par_chk_en,
    output logic               par_deassert,
    output logic [DATA_W-1:0]  P_DATA,
    output logic               data_valid,
    output logic               stp_err
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_W + 3);

    rx_state_e            state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]    p_data_q, p_data_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic                 par_en_q, par_en_d;
    logic                 par_flag_q, par_flag_d;
    logic                 par_chk_en_q, par_chk_en_d;
    logic                 par_deassert_q, par_deassert_d;
    logic                 data_valid_q, data_valid_d;
    logic                 stp_err_q, stp_err_d;

    logic [PRESC_W-1:0]   edge_cnt;
    logic                 smp_bit;
    logic                 run_c;
    logic                 start_c;
    logic                 last_c;
    logic                 dec_c;
    logic                 rdy_c;
    logic [PRESC_W-1:0]   half_c;

    assign run_c = (state_q != IDLE);

    uart_rx_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .CLK           (CLK),
        .RST           (RST),
        .rx_i          (RX_IN),
        .run_i         (run_c),
        .presc_i       (presc_q),
        .edge_cnt_o    (edge_cnt),
        .sampled_bit_o (smp_bit)
    );

    // Bit-time landmarks: last edge, vote edge, and first cycle the vote is visible
    always_comb begin
        half_c = presc_q >> 1;
        last_c = (edge_cnt == presc_q - PRESC_W'(1));
        dec_c  = (edge_cnt == half_c + PRESC_W'(SMP_OFS_DEC));
        rdy_c  = (edge_cnt == half_c + PRESC_W'(SMP_OFS_RDY));
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        p_data_d       = p_data_q;
        presc_d        = presc_q;
        par_en_d       = par_en_q;
        par_flag_d     = par_flag_q;
        par_chk_en_d   = 1'b0;
        par_deassert_d = 1'b0;
        data_valid_d   = 1'b0;
        stp_err_d      = stp_err_q;
        start_c        = 1'b0;

        case (state_q)
            IDLE: begin
                if (!RX_IN) start_c = 1'b1;
            end
            START: begin
                if (last_c) begin
                    state_d   = DATA;
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
`ifdef UART_RX_STRT_GLITCH_CHK_EN
                if (rdy_c && smp_bit) state_d = IDLE;
`endif
            end
            DATA: begin
                if (rdy_c) p_data_d = {smp_bit, p_data_q[DATA_W-1:1]};
                if (last_c) begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(DATA_W)) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (dec_c) par_chk_en_d = 1'b1;
                if (last_c) begin
                    par_flag_d = par_err;
                    bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (rdy_c) begin
                    stp_err_d    = ~smp_bit;
                    data_valid_d = smp_bit & (~par_en_q | ~par_flag_q);
                end
                // A low line on the final edge is the next start bit; take it without an idle cycle
                if (last_c) begin
                    state_d = IDLE;
                    if (!RX_IN) start_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_c) begin
            state_d        = START;
            bit_cnt_d      = '0;
            presc_d        = PRESC_W'(presc_legal(32'(Prescale)));
            par_en_d       = PAR_EN;
            par_flag_d     = 1'b0;
            par_deassert_d = 1'b1;
            stp_err_d      = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            p_data_q       <= '0;
            presc_q        <= PRESC_W'(PRESC_8);
            par_en_q       <= 1'b0;
            par_flag_q     <= 1'b0;
            par_chk_en_q   <= 1'b0;
            par_deassert_q <= 1'b0;
            data_valid_q   <= 1'b0;
            stp_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            p_data_q       <= p_data_d;
            presc_q        <= presc_d;
            par_en_q       <= par_en_d;
            par_flag_q     <= par_flag_d;
            par_chk_en_q   <= par_chk_en_d;
            par_deassert_q <= par_deassert_d;
            data_valid_q   <= data_valid_d;
            stp_err_q      <= stp_err_d;
        end
    end

    assign sampled_bit  = smp_bit;
    assign par_chk_en   = par_chk_en_q;
    assign par_deassert = par_deassert_q;
    assign P_DATA       = p_data_q;
    assign data_valid   = data_valid_q;
    assign stp_err      = stp_err_q;

endmodule
